spw_light_link_sequencer: RTL and testbench

Link start/retry sequencer for the SpaceWire light core. It replaces direct software writes to the 2-bit core control word. The block drives `ctrl_out` (bit0 = link_start, bit1 = link_disable) from a small FSM that enables the link, waits a programmable time for `link_running`, backs off and retries on timeout or link loss, and gives up after a programmable retry count. It exposes an Avalon-MM slave (4 word registers) and an interrupt to the Nios II subsystem.

---
 rtl/spw_light_link_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_spw_light_link_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_light_link_sequencer.sv
// SpaceWire light link start/retry sequencer with a 4-register Avalon-MM slave and a level irq.
// ctrl_out/irq are registered (1 cycle); readdata is combinational; no bus backpressure, so every write is accepted.
module spw_light_link_sequencer #(
    parameter int TIMEOUT_W       = 16,
    parameter int DEFAULT_TIMEOUT = 2000,
    parameter int BACKOFF_CYCLES  = 64,
    parameter int MAX_RETRY       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        link_running,
    input  logic        link_error,
    output logic [1:0]  ctrl_out,
    output logic        irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;
    localparam logic [2:0] S_FAILED  = 3'd5;

    localparam int                 BW        = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [BW-1:0]      BOFF_LOAD = BW'(BACKOFF_CYCLES);
    localparam logic [BW-1:0]      BOFF_ONE  = BW'(1);
    localparam logic [TIMEOUT_W-1:0] TMR_ONE = TIMEOUT_W'(1);

    logic                 en_q;
    logic                 irq_en_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [3:0]           maxretry_q;
    logic                 pend_q;

    logic [2:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [BW-1:0]        boff_q, boff_d;
    logic [3:0]           retry_q, retry_d;
    logic [3:0]           retry_inc;
    logic                 pend_set;
    logic [1:0]           ctrl_d;

    logic wr;
    logic wr_ctrl, wr_tmo, wr_stat, wr_max;
    logic restart;
    logic unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign wr_ctrl = wr && (address == 2'd0);
    assign wr_tmo  = wr && (address == 2'd1);
    assign wr_stat = wr && (address == 2'd2);
    assign wr_max  = wr && (address == 2'd3);
    // RESTART acts on the edge of the write itself; it is never stored
    assign restart = wr_ctrl & writedata[2];
    assign unused_wdata = ^writedata;

    assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        boff_d   = boff_q;
        retry_d  = retry_q;
        pend_set = 1'b0;
        if (!en_q) begin
            state_d = S_IDLE;
            timer_d = '0;
            boff_d  = '0;
            retry_d = '0;
        end else if (restart) begin
            state_d = S_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_START;
                S_START: begin
                    timer_d = (timeout_q == '0) ? TMR_ONE : timeout_q;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (link_running) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end else if (timer_q <= TMR_ONE) begin
                        state_d = S_BACKOFF;
                        retry_d = retry_inc;
                        boff_d  = BOFF_LOAD;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                S_RUN: begin
                    if (link_error || !link_running) begin
                        state_d  = S_BACKOFF;
                        retry_d  = 4'd1;
                        pend_set = 1'b1;
                        boff_d   = BOFF_LOAD;
                    end
                end
                S_BACKOFF: begin
                    if (boff_q <= BOFF_ONE) begin
                        if (retry_q > maxretry_q) begin
                            state_d  = S_FAILED;
                            pend_set = 1'b1;
                        end else begin
                            state_d = S_START;
                        end
                    end else begin
                        boff_d = boff_q - BOFF_ONE;
                    end
                end
                S_FAILED: state_d = S_FAILED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Control word follows the next state so it switches on the same edge as the FSM
    always_comb begin
        ctrl_d = 2'b10;
        if ((state_d == S_START) || (state_d == S_WAIT) || (state_d == S_RUN)) begin
            ctrl_d = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            timeout_q  <= TIMEOUT_W'(DEFAULT_TIMEOUT);
            maxretry_q <= 4'(MAX_RETRY);
            pend_q     <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            boff_q     <= '0;
            retry_q    <= '0;
            ctrl_out   <= 2'b10;
            irq        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= writedata[0];
                irq_en_q <= writedata[1];
            end
            if (wr_tmo) begin
                timeout_q <= writedata[TIMEOUT_W-1:0];
            end
            if (wr_max) begin
                maxretry_q <= writedata[3:0];
            end
            if (pend_set) begin
                pend_q <= 1'b1;
            end else if (wr_stat && writedata[8]) begin
                pend_q <= 1'b0;
            end
            state_q  <= state_d;
            timer_q  <= timer_d;
            boff_q   <= boff_d;
            retry_q  <= retry_d;
            ctrl_out <= ctrl_d;
            irq      <= pend_q & irq_en_q;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[1:0] = {irq_en_q, en_q};
            2'd1: readdata[TIMEOUT_W-1:0] = timeout_q;
            2'd2: begin
                readdata[2:0] = state_q;
                readdata[3]   = link_running;
                readdata[7:4] = retry_q;
                readdata[8]   = pend_q;
            end
            default: readdata[3:0] = maxretry_q;
        endcase
    end

endmodule

// File: tb/tb_spw_light_link_sequencer.sv
// Self-checking bench for spw_light_link_sequencer: reset readback table plus hand-written link scenarios.
module tb_spw_light_link_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        link_running = 1'b0;
    logic        link_error = 1'b0;
    logic [1:0]  ctrl_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t reset_tbl[4];

    spw_light_link_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .link_running (link_running),
        .link_error   (link_error),
        .ctrl_out     (ctrl_out),
        .irq          (irq)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] stat(input int s, input int lr, input int rc, input int p);
        return 32'(s) | (32'(lr) << 3) | (32'(rc) << 4) | (32'(p) << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected value is queued when the address is driven and popped when readdata settles
    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        address = a;
        #1;
        e = exp_q.pop_front();
        chk(name, readdata, e);
    endtask

    task automatic chk_out(input string name, input logic [1:0] ec, input logic ei);
        chk({name, "_ctrl"}, {30'd0, ctrl_out}, {30'd0, ec});
        chk({name, "_irq"}, {31'd0, irq}, {31'd0, ei});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_tbl[0] = '{2'd0, 32'd0,    "rst_ctrl"};
        reset_tbl[1] = '{2'd1, 32'd2000, "rst_timeout"};
        reset_tbl[2] = '{2'd2, 32'd0,    "rst_status"};
        reset_tbl[3] = '{2'd3, 32'd7,    "rst_maxretry"};

        // Reset readback
        tick(2);
        chk_out("in_reset", 2'b10, 1'b0);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            rd_check(reset_tbl[i].name, reset_tbl[i].addr, reset_tbl[i].exp);
        end
        chk_out("after_reset", 2'b10, 1'b0);

        // Link comes up 5 cycles into WAIT
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'd1);
        rd_check("en_write_edge", 2'd2, stat(0, 0, 0, 0));
        chk_out("en_write_edge", 2'b10, 1'b0);
        tick(1);
        rd_check("start", 2'd2, stat(1, 0, 0, 0));
        chk_out("start", 2'b01, 1'b0);
        tick(1);
        rd_check("wait", 2'd2, stat(2, 0, 0, 0));
        tick(4);
        rd_check("wait5", 2'd2, stat(2, 0, 0, 0));
        link_running = 1'b1;
        tick(1);
        rd_check("run", 2'd2, stat(3, 1, 0, 0));
        chk_out("run", 2'b01, 1'b0);

        // link_error pulse in RUN
        bus_wr(2'd0, 32'd3);
        link_error = 1'b1;
        tick(1);
        link_error = 1'b0;
        rd_check("err_backoff", 2'd2, stat(4, 1, 1, 1));
        chk_out("err_backoff", 2'b10, 1'b0);
        tick(1);
        chk_out("err_irq", 2'b10, 1'b1);
        tick(62);
        rd_check("err_boff_last", 2'd2, stat(4, 1, 1, 1));
        chk_out("err_boff_last", 2'b10, 1'b1);
        tick(1);
        rd_check("err_restart", 2'd2, stat(1, 1, 1, 1));
        chk_out("err_restart", 2'b01, 1'b1);
        tick(1);
        rd_check("err_rewait", 2'd2, stat(2, 1, 1, 1));
        tick(1);
        rd_check("err_rerun", 2'd2, stat(3, 1, 0, 1));
        bus_wr(2'd2, 32'h100);
        rd_check("w1c_run", 2'd2, stat(3, 1, 0, 0));
        chk_out("w1c_edge", 2'b01, 1'b1);
        tick(1);
        chk_out("w1c_irq_low", 2'b01, 1'b0);

        // Link loss, then EN cleared during BACKOFF
        link_running = 1'b0;
        tick(1);
        rd_check("loss_backoff", 2'd2, stat(4, 0, 1, 1));
        bus_wr(2'd0, 32'd2);
        rd_check("boff_en0_edge", 2'd2, stat(4, 0, 1, 1));
        tick(1);
        rd_check("boff_en0_idle", 2'd2, stat(0, 0, 0, 1));
        chk_out("boff_en0_idle", 2'b10, 1'b1);
        bus_wr(2'd2, 32'h100);
        rd_check("w1c_idle", 2'd2, stat(0, 0, 0, 0));

        // EN cleared during WAIT
        bus_wr(2'd0, 32'd3);
        tick(2);
        rd_check("wait_en0_pre", 2'd2, stat(2, 0, 0, 0));
        tick(2);
        bus_wr(2'd0, 32'd2);
        rd_check("wait_en0_edge", 2'd2, stat(2, 0, 0, 0));
        tick(1);
        rd_check("wait_en0_idle", 2'd2, stat(0, 0, 0, 0));
        chk_out("wait_en0_idle", 2'b10, 1'b0);

        // Three timed-out attempts then FAILED
        bus_wr(2'd1, 32'd4);
        bus_wr(2'd3, 32'd2);
        bus_wr(2'd0, 32'd3);
        tick(2);
        for (int a = 1; a <= 3; a++) begin
            rd_check("fail_wait_entry", 2'd2, stat(2, 0, a - 1, 0));
            tick(3);
            rd_check("fail_wait_4th", 2'd2, stat(2, 0, a - 1, 0));
            chk_out("fail_wait_4th", 2'b01, 1'b0);
            tick(1);
            rd_check("fail_backoff", 2'd2, stat(4, 0, a, 0));
            chk_out("fail_backoff", 2'b10, 1'b0);
            tick(63);
            rd_check("fail_boff_last", 2'd2, stat(4, 0, a, 0));
            tick(1);
            if (a < 3) begin
                rd_check("fail_retry_start", 2'd2, stat(1, 0, a, 0));
                tick(1);
            end else begin
                rd_check("failed", 2'd2, stat(5, 0, 3, 1));
                chk_out("failed", 2'b10, 1'b0);
            end
        end
        tick(1);
        chk_out("failed_irq", 2'b10, 1'b1);
        bus_wr(2'd2, 32'h100);
        rd_check("failed_w1c", 2'd2, stat(5, 0, 3, 0));
        tick(1);
        chk_out("failed_w1c_irq", 2'b10, 1'b0);
        bus_wr(2'd0, 32'd7);
        rd_check("restart_idle", 2'd2, stat(0, 0, 0, 0));
        chk_out("restart_idle", 2'b10, 1'b0);
        tick(1);
        rd_check("restart_start", 2'd2, stat(1, 0, 0, 0));
        rd_check("ctrl_readback", 2'd0, 32'd3);

        // RESTART and EN=0 in the same write
        bus_wr(2'd0, 32'd4);
        rd_check("restart_en0", 2'd2, stat(0, 0, 0, 0));
        chk_out("restart_en0", 2'b10, 1'b0);
        tick(2);
        rd_check("restart_en0_hold", 2'd2, stat(0, 0, 0, 0));
        rd_check("ctrl_cleared", 2'd0, 32'd0);

        // MAXRETRY=0, TIMEOUT=0
        bus_wr(2'd3, 32'd0);
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd0, 32'd1);
        tick(2);
        rd_check("t0_wait", 2'd2, stat(2, 0, 0, 0));
        tick(1);
        rd_check("t0_backoff", 2'd2, stat(4, 0, 1, 0));
        tick(63);
        rd_check("t0_boff_last", 2'd2, stat(4, 0, 1, 0));
        tick(1);
        rd_check("t0_failed", 2'd2, stat(5, 0, 1, 1));
        tick(1);
        chk_out("t0_failed_noirq", 2'b10, 1'b0);

        // Reset asserted while in WAIT
        bus_wr(2'd0, 32'd5);
        tick(2);
        rd_check("pre_reset_wait", 2'd2, stat(2, 0, 0, 1));
        chk_out("pre_reset_wait", 2'b01, 1'b0);
        reset = 1'b1;
        #1;
        chk_out("mid_reset", 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_check(reset_tbl[i].name, reset_tbl[i].addr, reset_tbl[i].exp);
        end
        tick(3);
        chk_out("reset_held", 2'b10, 1'b0);
        reset = 1'b0;
        tick(2);
        chk_out("after_rerelease", 2'b10, 1'b0);
        rd_check("after_rerelease", 2'd2, stat(0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
